// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts
// one byte out on device-generated clock edges, then checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       kb_clk_in,
    input  logic       kb_data_in,
    output logic       kb_clk_oe,
    output logic       kb_data_oe
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    localparam logic [31:0] INH_LAST = INHIBIT_CYCLES - 32'd1;
    localparam logic [31:0] TO_LAST  = TIMEOUT_CYCLES - 32'd1;

    state_t      state_r;
    logic        clk_meta_r, clk_sync_r, clk_prev_r;
    logic        data_meta_r, data_sync_r;
    logic [9:0]  shreg_r;
    logic [3:0]  bitcnt_r;
    logic [31:0] cnt_r;
    logic        fall_s;
    logic        wd_active_s;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    assign fall_s      = clk_prev_r & ~clk_sync_r;
    assign wd_active_s = (state_r == ST_RTS) || (state_r == ST_SEND) ||
                         (state_r == ST_ACK) || (state_r == ST_WAIT_IDLE);

    // Two-flop synchronisers for both bus lines plus the clock-edge history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            clk_prev_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= kb_clk_in;
            clk_sync_r  <= clk_meta_r;
            clk_prev_r  <= clk_sync_r;
            data_meta_r <= kb_data_in;
            data_sync_r <= data_meta_r;
        end
    end

    // Transmit sequencer with registered handshake, status pulses and line drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            shreg_r    <= 10'd0;
            bitcnt_r   <= 4'd0;
            cnt_r      <= 32'd0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            kb_clk_oe  <= 1'b0;
            kb_data_oe <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (wd_active_s && !fall_s && (cnt_r == TO_LAST)) begin
                // Device went quiet: release the bus and give up on this byte.
                kb_clk_oe  <= 1'b0;
                kb_data_oe <= 1'b0;
                error      <= 1'b1;
                tx_ready   <= 1'b1;
                busy       <= 1'b0;
                state_r    <= ST_IDLE;
            end else begin
                if (wd_active_s) begin
                    cnt_r <= fall_s ? 32'd0 : cnt_r + 32'd1;
                end else begin
                    cnt_r <= cnt_r;
                end
                case (state_r)
                    ST_IDLE: begin
                        kb_clk_oe  <= 1'b0;
                        kb_data_oe <= 1'b0;
                        if (tx_valid) begin
                            shreg_r   <= {1'b1, odd_parity(tx_data), tx_data};
                            cnt_r     <= 32'd0;
                            bitcnt_r  <= 4'd0;
                            kb_clk_oe <= 1'b1;
                            tx_ready  <= 1'b0;
                            busy      <= 1'b1;
                            state_r   <= ST_INHIBIT;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_INHIBIT: begin
                        if (cnt_r == INH_LAST) begin
                            kb_clk_oe  <= 1'b0;
                            kb_data_oe <= 1'b1;
                            cnt_r      <= 32'd0;
                            state_r    <= ST_RTS;
                        end else begin
                            cnt_r <= cnt_r + 32'd1;
                        end
                    end
                    ST_RTS, ST_SEND: begin
                        if (fall_s) begin
                            kb_data_oe <= ~shreg_r[0];
                            shreg_r    <= {1'b1, shreg_r[9:1]};
                            bitcnt_r   <= bitcnt_r + 4'd1;
                            // The stop bit goes out on the tenth edge; the next edge is the ACK.
                            if (bitcnt_r == 4'd9) begin
                                state_r <= ST_ACK;
                            end else begin
                                state_r <= ST_SEND;
                            end
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    ST_ACK: begin
                        kb_data_oe <= 1'b0;
                        if (fall_s) begin
                            if (!data_sync_r) begin
                                state_r <= ST_WAIT_IDLE;
                            end else begin
                                error    <= 1'b1;
                                tx_ready <= 1'b1;
                                busy     <= 1'b0;
                                state_r  <= ST_IDLE;
                            end
                        end else begin
                            state_r <= ST_ACK;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (clk_sync_r && data_sync_r) begin
                            done     <= 1'b1;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state_r  <= ST_IDLE;
                        end else begin
                            state_r <= ST_WAIT_IDLE;
                        end
                    end
                    default: begin
                        kb_clk_oe  <= 1'b0;
                        kb_data_oe <= 1'b0;
                        tx_ready   <= 1'b1;
                        busy       <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND bus and a 40-clk device clock model.
module tb_ps2_host_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, error;
    logic       kb_clk_in, kb_data_in, kb_clk_oe, kb_data_oe;
    logic       dev_clk, dev_data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int err_cyc = 0;
    int last_fall_cyc = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .error(error),
        .kb_clk_in(kb_clk_in), .kb_data_in(kb_data_in),
        .kb_clk_oe(kb_clk_oe), .kb_data_oe(kb_data_oe)
    );

    assign kb_clk_in  = dev_clk & ~kb_clk_oe;
    assign kb_data_in = dev_data & ~kb_data_oe;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (done && error) both_cnt++;
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic measure_inhibit(output int n);
        n = 0;
        while (kb_clk_oe === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Device: drives nfalls clock pulses, sampling the data line on each rising edge.
    task automatic dev_clock(input int nfalls, input logic nack, output logic [9:0] frame);
        frame = 10'd0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < nfalls; i++) begin
            if (i == 10) begin
                dev_data = nack;
                repeat (5) @(negedge clk);
            end
            dev_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (20) @(negedge clk);
            if (i < 10) frame[i] = kb_data_in;
            dev_clk = 1'b1;
            if (i == 10) dev_data = 1'b1;
            repeat (20) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({tx_ready, busy, done, error, kb_clk_oe, kb_data_oe} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 100000",
                     {tx_ready, busy, done, error, kb_clk_oe, kb_data_oe});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_send(input logic [7:0] d, input logic [9:0] exp_frame);
        int n;
        logic [9:0] frame;
        done_cnt = 0;
        err_cnt  = 0;
        start_tx(d);
        vectors++;
        if ({tx_ready, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL busy_after_accept %h: got %b want 01", d, {tx_ready, busy});
        end
        measure_inhibit(n);
        vectors++;
        if (n !== 8) begin
            miscompares++;
            $display("FAIL inhibit_len %h: got %0d want 8", d, n);
        end
        vectors++;
        if ({kb_data_oe, kb_data_in} !== 2'b10) begin
            miscompares++;
            $display("FAIL start_bit %h: got oe/line %b want 10", d, {kb_data_oe, kb_data_in});
        end
        dev_clock(11, 1'b0, frame);
        vectors++;
        if (frame !== exp_frame) begin
            miscompares++;
            $display("FAIL frame %h: got %h want %h", d, frame, exp_frame);
        end
        vectors++;
        if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) begin
            miscompares++;
            $display("FAIL done_pulse %h: got done=%0d err=%0d want 1/0", d, done_cnt, err_cnt);
        end
        vectors++;
        if ({tx_ready, busy, kb_clk_oe, kb_data_oe} !== 4'b1000) begin
            miscompares++;
            $display("FAIL idle_after %h: got %b want 1000", d,
                     {tx_ready, busy, kb_clk_oe, kb_data_oe});
        end
    endtask

    task automatic test_nack;
        int n;
        logic [9:0] frame;
        done_cnt = 0;
        err_cnt  = 0;
        start_tx(8'hF4);
        measure_inhibit(n);
        dev_clock(11, 1'b1, frame);
        vectors++;
        if ({done_cnt, err_cnt} !== {32'd0, 32'd1}) begin
            miscompares++;
            $display("FAIL nack_pulse: got done=%0d err=%0d want 0/1", done_cnt, err_cnt);
        end
        vectors++;
        if ({tx_ready, busy, kb_clk_oe, kb_data_oe} !== 4'b1000) begin
            miscompares++;
            $display("FAIL nack_idle: got %b want 1000", {tx_ready, busy, kb_clk_oe, kb_data_oe});
        end
    endtask

    task automatic test_timeout;
        int n;
        logic [9:0] frame;
        done_cnt = 0;
        err_cnt  = 0;
        start_tx(8'hA5);
        measure_inhibit(n);
        dev_clock(4, 1'b0, frame);
        repeat (80) @(negedge clk);
        vectors++;
        if (frame[3:0] !== 4'b0101) begin
            miscompares++;
            $display("FAIL timeout_bits: got %b want 0101", frame[3:0]);
        end
        vectors++;
        if ({done_cnt, err_cnt} !== {32'd0, 32'd1}) begin
            miscompares++;
            $display("FAIL timeout_pulse: got done=%0d err=%0d want 0/1", done_cnt, err_cnt);
        end
        // 3 cycles of synchroniser/edge lag plus the 64-cycle watchdog.
        vectors++;
        if (err_cyc - last_fall_cyc !== 67) begin
            miscompares++;
            $display("FAIL timeout_delay: got %0d want 67", err_cyc - last_fall_cyc);
        end
        vectors++;
        if ({tx_ready, kb_clk_oe, kb_data_oe} !== 3'b100) begin
            miscompares++;
            $display("FAIL timeout_release: got %b want 100", {tx_ready, kb_clk_oe, kb_data_oe});
        end
    endtask

    task automatic test_reset_mid_send;
        int n;
        logic [9:0] frame;
        start_tx(8'h00);
        measure_inhibit(n);
        dev_clock(3, 1'b0, frame);
        vectors++;
        if ({busy, kb_data_oe} !== 2'b11) begin
            miscompares++;
            $display("FAIL pre_reset_drive: got %b want 11", {busy, kb_data_oe});
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({kb_clk_oe, kb_data_oe} !== 2'b00) begin
            miscompares++;
            $display("FAIL async_release: got %b want 00", {kb_clk_oe, kb_data_oe});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({tx_ready, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b want 10", {tx_ready, busy});
        end
        test_send(8'hFF, 10'h3FF);
    endtask

    task automatic test_back_to_back;
        int n;
        logic [9:0] frame;
        done_cnt = 0;
        err_cnt  = 0;
        start_tx(8'h3C);
        @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        measure_inhibit(n);
        dev_clock(11, 1'b0, frame);
        repeat (100) @(negedge clk);
        vectors++;
        if (frame !== 10'h33C) begin
            miscompares++;
            $display("FAIL busy_ignore_frame: got %h want 33c", frame);
        end
        vectors++;
        if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) begin
            miscompares++;
            $display("FAIL busy_ignore_pulses: got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
        end
        vectors++;
        if ({tx_ready, kb_clk_oe, kb_data_oe} !== 3'b100) begin
            miscompares++;
            $display("FAIL busy_ignore_idle: got %b want 100", {tx_ready, kb_clk_oe, kb_data_oe});
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        test_reset();
        test_send(8'hED, 10'h3ED);
        test_send(8'h07, 10'h207);
        test_send(8'h00, 10'h300);
        test_nack();
        test_timeout();
        test_reset_mid_send();
        test_back_to_back();
        vectors++;
        if (both_cnt !== 0) begin
            miscompares++;
            $display("FAIL done_and_error: got %0d overlapping cycles want 0", both_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
